// File: rtl/pipe_writeback_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter slice.
// XLEN / RF_ADDR_W / N_REGS mirror the core-wide configuration values.
// wbEntry_t is one pending register-file write (address + data).
package pipe_writeback_arbiter_pkg;
  localparam int XLEN      = 32;
  localparam int RF_ADDR_W = 5;
  localparam int N_REGS    = 32;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wbEntry_t;

  localparam int ENTRY_W = $bits(wbEntry_t);

  // x0 is hardwired zero: writes to it are never architecturally visible.
  function automatic logic rdLive(input logic [RF_ADDR_W-1:0] rd);
    return rd != '0;
  endfunction
endpackage

// File: rtl/pipe_writeback_arbiter_if.sv
// Bus bundle between the pipeline/LLU/hazard side (master) and the
// writeback arbiter (slave).
//   i_wb_*   : Writeback stage write request (we, rd, data)
//   i_llu_*  : LLU result handshake (valid, rd, data); o_llu_ready back
//   i_iss_*  : LLU issue notification from Execute (valid, rd)
//   o_rf_*   : register-file write port (we, rd, wd)
//   o_busy_vec, o_stall_req, o_err : scoreboard / hazard / error outputs
interface pipe_writeback_arbiter_if;
  import pipe_writeback_arbiter_pkg::*;

  logic                 i_wb_we;
  logic [RF_ADDR_W-1:0] i_wb_rd;
  logic [XLEN-1:0]      i_wb_data;
  logic                 i_llu_valid;
  logic                 o_llu_ready;
  logic [RF_ADDR_W-1:0] i_llu_rd;
  logic [XLEN-1:0]      i_llu_data;
  logic                 i_iss_valid;
  logic [RF_ADDR_W-1:0] i_iss_rd;
  logic                 o_rf_we;
  logic [RF_ADDR_W-1:0] o_rf_rd;
  logic [XLEN-1:0]      o_rf_wd;
  logic [N_REGS-1:0]    o_busy_vec;
  logic                 o_stall_req;
  logic                 o_err;

  modport master (
    output i_wb_we, i_wb_rd, i_wb_data, i_llu_valid, i_llu_rd, i_llu_data,
           i_iss_valid, i_iss_rd,
    input  o_llu_ready, o_rf_we, o_rf_rd, o_rf_wd, o_busy_vec, o_stall_req, o_err
  );

  modport slave (
    input  i_wb_we, i_wb_rd, i_wb_data, i_llu_valid, i_llu_rd, i_llu_data,
           i_iss_valid, i_iss_rd,
    output o_llu_ready, o_rf_we, o_rf_rd, o_rf_wd, o_busy_vec, o_stall_req, o_err
  );
endinterface

// File: rtl/pipe_writeback_arbiter_fifo.sv
// pipe_wb_fifo: BUF_DEPTH x W result buffer for LLU writebacks.
// Ports: clk, rstn (async active-low), push/wdata, pop/rdata (head, valid
// when !empty), full, empty, count. Pointers wrap at BUF_DEPTH; push while
// full and pop while empty are ignored. Storage is not reset.
module pipe_wb_fifo #(
  parameter int BUF_DEPTH = 2,
  parameter int W         = 37
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             push,
  input  logic [W-1:0]                     wdata,
  input  logic                             pop,
  output logic [W-1:0]                     rdata,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   count
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [W-1:0]     mem [BUF_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full   = (count == CNT_W'(BUF_DEPTH));
  assign empty  = (count == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign rdata  = mem[rdPtr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= ptrInc(wrPtr);
      if (doPop)  rdPtr <= ptrInc(rdPtr);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wdata;
  end
endmodule

// File: rtl/riscv_mux.sv
// Generic N-input one-hot-free select mux used across the core.
// Ports: muxIn (N_MUX_IN packed words), sel (index), muxOut (selected word).
module riscv_mux #(
  parameter int N_MUX_IN = 2,
  parameter int W        = 32
) (
  input  logic [N_MUX_IN-1:0][W-1:0]    muxIn,
  input  logic [$clog2(N_MUX_IN)-1:0]   sel,
  output logic [W-1:0]                  muxOut
);
  assign muxOut = muxIn[sel];
endmodule

// File: rtl/pipe_writeback_arbiter.sv
// pipe_writeback_arbiter: shares the register-file write port between the
// in-order Writeback stage (absolute priority, zero latency) and buffered
// long-latency-unit results that drain on idle write-port cycles.
// Ports: i_clk, i_rstn (async active-low), bus (slave modport of
// pipe_writeback_arbiter_if: WB request, LLU handshake, issue notify,
// register-file write port, busy scoreboard, stall request, sticky error).
module pipe_writeback_arbiter
  import pipe_writeback_arbiter_pkg::*;
#(
  parameter int BUF_DEPTH  = 2,
  parameter int STARVE_MAX = 8
) (
  input logic                      i_clk,
  input logic                      i_rstn,
  pipe_writeback_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int ST_W  = $clog2(STARVE_MAX + 1);

  logic                         wbAct;
  logic                         lluXfer;
  logic                         push;
  logic                         pop;
  logic                         fifoFull;
  logic                         fifoEmpty;
  logic [CNT_W-1:0]             fifoCount;
  logic [CNT_W-1:0]             countNext;
  wbEntry_t                     pushEntry;
  wbEntry_t                     headEntry;
  logic [1:0][ENTRY_W-1:0]      muxIn;
  logic [ENTRY_W-1:0]           muxOut;
  logic [N_REGS-1:0]            busyVec;
  logic [N_REGS-1:0]            busySet;
  logic [N_REGS-1:0]            busyClr;
  logic [N_REGS-1:0]            busyNext;
  logic [ST_W-1:0]              starveCnt;
  logic [ST_W-1:0]              starveNext;
  logic                         stallReq;
  logic                         errFlag;
  logic                         errHit;

  assign wbAct     = bus.i_wb_we & rdLive(bus.i_wb_rd);
  assign pop       = ~wbAct & ~fifoEmpty;
  // Ready depends only on the registered fill level, so a full FIFO is not
  // ready even in a cycle where it pops.
  assign lluXfer   = bus.i_llu_valid & ~fifoFull;
  assign push      = lluXfer & rdLive(bus.i_llu_rd);
  assign pushEntry = '{rd: bus.i_llu_rd, data: bus.i_llu_data};

  pipe_wb_fifo #(
    .BUF_DEPTH (BUF_DEPTH),
    .W         (ENTRY_W)
  ) u_fifo (
    .clk   (i_clk),
    .rstn  (i_rstn),
    .push  (push),
    .wdata (pushEntry),
    .pop   (pop),
    .rdata (headEntry),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  // Input 0 is forced to zero when nothing drains so an idle port reads 0.
  assign muxIn[1] = {bus.i_wb_rd, bus.i_wb_data};
  assign muxIn[0] = pop ? headEntry : '0;

  riscv_mux #(
    .N_MUX_IN (2),
    .W        (ENTRY_W)
  ) u_portMux (
    .muxIn  (muxIn),
    .sel    (wbAct),
    .muxOut (muxOut)
  );

  assign bus.o_rf_we              = wbAct | pop;
  assign {bus.o_rf_rd, bus.o_rf_wd} = muxOut;
  assign bus.o_llu_ready          = ~fifoFull;
  assign bus.o_busy_vec           = busyVec;
  assign bus.o_stall_req          = stallReq;
  assign bus.o_err                = errFlag;

  always_comb begin
    busySet = '0;
    busyClr = '0;
    if (bus.i_iss_valid && rdLive(bus.i_iss_rd)) busySet[bus.i_iss_rd] = 1'b1;
    if (pop) busyClr[headEntry.rd] = 1'b1;
    // OR-ing the set after the clear lets a same-cycle re-issue win.
    busyNext    = (busyVec & ~busyClr) | busySet;
    busyNext[0] = 1'b0;
  end

  always_comb begin
    countNext = fifoCount;
    if (push && !pop)      countNext = fifoCount + CNT_W'(1);
    else if (pop && !push) countNext = fifoCount - CNT_W'(1);
  end

  always_comb begin
    starveNext = '0;
    if (!fifoEmpty && !pop)
      starveNext = (starveCnt == ST_W'(STARVE_MAX)) ? starveCnt : starveCnt + ST_W'(1);
  end

  assign errHit = (wbAct & busyVec[bus.i_wb_rd])
                | (bus.i_iss_valid & rdLive(bus.i_iss_rd) & busyVec[bus.i_iss_rd])
                | (lluXfer & rdLive(bus.i_llu_rd) & ~busyVec[bus.i_llu_rd]);

  // Registered scoreboard / hazard / error state boundary
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      busyVec   <= '0;
      starveCnt <= '0;
      stallReq  <= 1'b0;
      errFlag   <= 1'b0;
    end else begin
      busyVec   <= busyNext;
      starveCnt <= starveNext;
      stallReq  <= (countNext == CNT_W'(BUF_DEPTH)) | (starveNext == ST_W'(STARVE_MAX));
      errFlag   <= errFlag | errHit;
    end
  end
endmodule
